// File: rtl/aes_pkg.sv
// Shared widths and types for the AES block path, plus the byte-reversal helper
// used by the receive packer.
package aes_pkg;

    localparam int BLOCK_W         = 128;
    localparam int WORD_W          = 32;
    localparam int WORDS_PER_BLOCK = 4;

    typedef logic [BLOCK_W-1:0] block_t;
    typedef logic [WORD_W-1:0]  word_t;

    // Little-endian bus word to AES byte order: byte 0 becomes the MSB byte.
    function automatic word_t byte_swap(input word_t w);
        return {w[7:0], w[15:8], w[23:16], w[31:24]};
    endfunction

endpackage

// File: rtl/block_fifo.sv
// Generic DEPTH x block_t synchronous FIFO with show-ahead head, count and flags.
// A push while full or a pop while empty is ignored.
module block_fifo
    import aes_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  block_t           push_data,
    input  logic             pop,
    output block_t           head,
    output logic             empty,
    output logic             full,
    output logic [CNT_W-1:0] count
);

    block_t           mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             push_ok;
    logic             pop_ok;

    assign empty   = (count == '0);
    assign full    = (count == CNT_W'(DEPTH));
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign head    = empty ? '0 : mem[rd_ptr];

    // Storage carries no reset; the empty flag masks stale entries on the head.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            if (push_ok && !pop_ok) begin
                count <= count + CNT_W'(1);
            end else if (!push_ok && pop_ok) begin
                count <= count - CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/rx_block_packer.sv
// Packs 32-bit bus words into 128-bit blocks and queues them for the AES core.
// Define RX_PACKER_BYTESWAP_EN to byte-reverse every accepted word before staging.
module rx_block_packer
    import aes_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       wr_valid,
    input  logic [31:0]                wr_data,
    output logic                       wr_ready,
    input  logic                       flush,
    input  logic                       rcv_deq,
    output logic [127:0]               rcv_fifo_out,
    output logic                       rcv_fifo_empty,
    output logic                       rcv_fifo_full,
    output logic [$clog2(DEPTH+1)-1:0] block_count,
    output logic [1:0]                 word_idx,
    output logic                       overflow_err,
    output logic                       underflow_err,
    input  logic                       clear_err
);

    logic [95:0] staging;
    word_t       word_in;
    logic        accept;
    logic        push;

`ifdef RX_PACKER_BYTESWAP_EN
    assign word_in = byte_swap(wr_data);
`else
    assign word_in = wr_data;
`endif

    // Handshake: a word transfers on any rising edge where wr_valid && wr_ready;
    // only the block-completing word can stall, and flush refuses the word outright.
    assign wr_ready = !flush && !((word_idx == 2'd3) && rcv_fifo_full);
    assign accept   = wr_valid && wr_ready;
    assign push     = accept && (word_idx == 2'd3);

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            staging  <= '0;
            word_idx <= '0;
        end else if (accept) begin
            if (word_idx == 2'd3) begin
                staging  <= '0;
                word_idx <= '0;
            end else begin
                case (word_idx)
                    2'd0:    staging[95:64] <= word_in;
                    2'd1:    staging[63:32] <= word_in;
                    default: staging[31:0]  <= word_in;
                endcase
                word_idx <= word_idx + 2'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst || clear_err) begin
            overflow_err  <= 1'b0;
            underflow_err <= 1'b0;
        end else begin
            if (wr_valid && !wr_ready) begin
                overflow_err <= 1'b1;
            end
            if (rcv_deq && rcv_fifo_empty) begin
                underflow_err <= 1'b1;
            end
        end
    end

    block_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data ({staging, word_in}),
        .pop       (rcv_deq),
        .head      (rcv_fifo_out),
        .empty     (rcv_fifo_empty),
        .full      (rcv_fifo_full),
        .count     (block_count)
    );

endmodule
